// File: rtl/pipe_scroller.sv
// Side-scrolling pipe playfield: shifts columns left on each tick edge, inserts pseudo-random
// pipes every SPACING steps and counts pipes that pass the bird column.
module pipe_scroller #(
    parameter int unsigned COLS     = 16,
    parameter int unsigned ROWS     = 8,
    parameter int unsigned GAP      = 3,
    parameter int unsigned SPACING  = 4,
    parameter int unsigned BIRD_COL = 2
) (
    input  logic                   Clock,
    input  logic                   RST,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   collide,
    output logic [COLS*ROWS-1:0]   field,
    output logic [ROWS-1:0]        bird_col_mask,
    output logic [7:0]             score,
    output logic                   running
);

    localparam int unsigned CW   = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam int unsigned GMOD = ROWS - GAP + 1;

    typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

    state_e                r_state, w_state_nxt;
    logic                  r_tick_d;
    logic [7:0]            r_lfsr;
    logic [COLS*ROWS-1:0]  r_field, w_field_nxt;
    logic [7:0]            r_score, w_score_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;

    logic                  w_step;
    logic                  w_lfsr_fb;
    logic [7:0]            w_g;
    logic [ROWS-1:0]       w_gap_mask;
    logic [ROWS-1:0]       w_pipe_col;
    logic [ROWS-1:0]       w_new_col;
    logic                  w_last_slot;

    assign w_step      = tick & ~r_tick_d;
    // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1 in left-shifting Fibonacci form
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_g         = r_lfsr % 8'(GMOD);
    assign w_gap_mask  = ROWS'((1 << GAP) - 1) << w_g;
    assign w_pipe_col  = ~w_gap_mask;
    assign w_last_slot = (r_cnt == CW'(SPACING - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_field_nxt = r_field;
        w_score_nxt = r_score;
        w_cnt_nxt   = r_cnt;
        w_new_col   = '0;
        unique case (r_state)
            StIdle: begin
                w_field_nxt = '0;
                w_score_nxt = '0;
                w_cnt_nxt   = '0;
                if (start) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (collide) begin
                    w_state_nxt = StOver;
                end else if (w_step) begin
                    w_new_col   = w_last_slot ? w_pipe_col : '0;
                    w_cnt_nxt   = w_last_slot ? '0 : r_cnt + CW'(1);
                    w_field_nxt = {w_new_col, r_field[COLS*ROWS-1:ROWS]};
                    if ((|r_field[BIRD_COL*ROWS +: ROWS]) && (r_score != 8'hFF)) begin
                        w_score_nxt = r_score + 8'd1;
                    end
                end
            end
            StOver: begin
                // Clear on the way out so IDLE is entered with an empty field
                if (start) begin
                    w_state_nxt = StIdle;
                    w_field_nxt = '0;
                    w_score_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge RST) begin
        if (!RST) begin
            r_state  <= StIdle;
            r_tick_d <= 1'b0;
            r_lfsr   <= 8'hA5;
            r_field  <= '0;
            r_score  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tick_d <= tick;
            r_lfsr   <= {r_lfsr[6:0], w_lfsr_fb};
            r_field  <= w_field_nxt;
            r_score  <= w_score_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign field         = r_field;
    assign bird_col_mask = r_field[BIRD_COL*ROWS +: ROWS];
    assign score         = r_score;
    assign running      = (r_state == StRun);

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomized bench for pipe_scroller: a queue-of-columns game model is compared with the DUT
// every cycle, plus directed checks for reset, tick edges, collision and score saturation.
module tb_pipe_scroller;

    localparam int COLS     = 16;
    localparam int ROWS     = 8;
    localparam int GAP      = 3;
    localparam int SPACING  = 4;
    localparam int BIRD_COL = 2;
    localparam int FW       = COLS * ROWS;

    logic              Clock;
    logic              RST;
    logic              tick;
    logic              start;
    logic              collide;
    logic [FW-1:0]     field;
    logic [ROWS-1:0]   bird_col_mask;
    logic [7:0]        score;
    logic              running;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_scroller #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .GAP      (GAP),
        .SPACING  (SPACING),
        .BIRD_COL (BIRD_COL)
    ) u_dut (
        .Clock         (Clock),
        .RST           (RST),
        .tick          (tick),
        .start         (start),
        .collide       (collide),
        .field         (field),
        .bird_col_mask (bird_col_mask),
        .score         (score),
        .running       (running)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit [7:0]       seq [255];
    bit [ROWS-1:0]  m_q [$];
    int             m_state;      // 0 idle, 1 run, 2 over
    int             m_score;
    int             m_cnt;
    int             m_cyc;
    bit             m_tprev;
    bit             m_pipe_new;
    bit             m_en = 1'b0;

    function automatic bit [ROWS-1:0] pipe_of(input int g);
        bit [ROWS-1:0] c;
        for (int r = 0; r < ROWS; r++) c[r] = (r < g) || (r >= g + GAP);
        return c;
    endfunction

    function automatic int zeros_of(input logic [ROWS-1:0] c);
        int n = 0;
        for (int r = 0; r < ROWS; r++) if (c[r] === 1'b0) n++;
        return n;
    endfunction

    function automatic int first_zero(input logic [ROWS-1:0] c);
        for (int r = 0; r < ROWS; r++) if (c[r] === 1'b0) return r;
        return ROWS;
    endfunction

    task automatic m_clear();
        m_q.delete();
        for (int c = 0; c < COLS; c++) m_q.push_back('0);
        m_score = 0;
        m_cnt   = 0;
    endtask

    initial begin
        bit [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < 255; i++) begin
            seq[i] = v;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
        m_clear();
    end

    always @(posedge Clock or negedge RST) begin
        bit       step;
        bit [7:0] lf;
        if (!RST) begin
            m_clear();
            m_state    = 0;
            m_cyc      = 0;
            m_tprev    = 1'b0;
            m_pipe_new = 1'b0;
        end else begin
            step       = tick && !m_tprev;
            m_tprev    = tick;
            lf         = seq[m_cyc % 255];
            m_cyc      = m_cyc + 1;
            m_pipe_new = 1'b0;
            case (m_state)
                0: if (start) m_state = 1;
                1: begin
                    if (collide) begin
                        m_state = 2;
                    end else if (step) begin
                        if (m_q[BIRD_COL] != 0 && m_score < 255) m_score++;
                        void'(m_q.pop_front());
                        if (m_cnt == SPACING - 1) begin
                            m_q.push_back(pipe_of(int'(lf) % (ROWS - GAP + 1)));
                            m_pipe_new = 1'b1;
                        end else begin
                            m_q.push_back('0);
                        end
                        m_cnt = (m_cnt + 1) % SPACING;
                    end
                end
                default: if (start) begin
                    m_state = 0;
                    m_clear();
                end
            endcase
        end
    end

    always @(negedge Clock) begin
        logic [FW-1:0]   exp_f;
        logic [ROWS-1:0] col;
        int              g;
        if (m_en && RST) begin
            for (int c = 0; c < COLS; c++) exp_f[c*ROWS +: ROWS] = m_q[c];
            check_eq("field", field, exp_f);
            check_eq("score", score, m_score);
            check_eq("running", running, m_state == 1);
            check_eq("bird_mask", bird_col_mask, m_q[BIRD_COL]);
            if (m_pipe_new) begin
                col = field[(COLS-1)*ROWS +: ROWS];
                g   = first_zero(col);
                check_eq("gap_zeros", zeros_of(col), GAP);
                check_eq("gap_range", g <= ROWS - GAP, 1);
                check_eq("gap_contig", col, pipe_of(g));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_tick();
        @(negedge Clock) tick = 1'b1;
        @(negedge Clock) tick = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge Clock) start = 1'b1;
        @(negedge Clock) start = 1'b0;
    endtask

    initial begin
        logic [FW-1:0] f0;
        logic [7:0]    s0;
        RST = 1'b1; tick = 1'b0; start = 1'b0; collide = 1'b0;
        #1 RST = 1'b0;
        repeat (2) @(negedge Clock);
        m_en = 1'b1;
        check_eq("rst_field", field, 0);
        check_eq("rst_score", score, 0);
        check_eq("rst_running", running, 0);
        RST = 1'b1;

        // Step coinciding with IDLE->RUN must not shift
        @(negedge Clock) begin start = 1'b1; tick = 1'b1; end
        @(negedge Clock) begin start = 1'b0; tick = 1'b0; end
        check_eq("entry_running", running, 1);
        check_eq("entry_field", field, 0);

        repeat (4) pulse_tick();
        check_eq("first_cols_zero", field[(COLS-1)*ROWS-1:0], 0);
        check_eq("first_pipe_zeros", zeros_of(field[(COLS-1)*ROWS +: ROWS]), GAP);
        check_eq("first_score", score, 0);
        check_eq("first_running", running, 1);

        // Level tick held 10 cycles gives a single shift
        @(negedge Clock) begin f0 = field; tick = 1'b1; end
        repeat (10) @(negedge Clock);
        tick = 1'b0;
        @(negedge Clock);
        check_eq("hold_one_shift", field[(COLS-1)*ROWS-1:0], f0[FW-1:ROWS]);

        // Random ticks; start in RUN is ignored
        repeat (400) @(negedge Clock) begin
            tick  = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 15) == 0);
        end
        @(negedge Clock) begin tick = 1'b0; start = 1'b0; end
        repeat (1150) pulse_tick();
        check_eq("score_sat", score, 255);

        // Collide together with a tick edge: frozen in OVER
        @(negedge Clock) begin f0 = field; s0 = score; tick = 1'b1; collide = 1'b1; end
        @(negedge Clock) begin collide = 1'b0; tick = 1'b0; end
        check_eq("over_field", field, f0);
        check_eq("over_score", score, s0);
        check_eq("over_running", running, 0);
        repeat (3) pulse_tick();
        check_eq("over_frozen", field, f0);
        pulse_start();
        check_eq("restart_field", field, 0);
        check_eq("restart_score", score, 0);

        // Collide in IDLE is ignored
        repeat (5) @(negedge Clock) collide = 1'b1;
        @(negedge Clock) collide = 1'b0;
        check_eq("idle_collide", running, 0);

        pulse_start();
        repeat (60) @(negedge Clock) tick = 1'($urandom_range(0, 1));
        // Asynchronous reset between edges
        @(negedge Clock);
        #1 RST = 1'b0;
        #1;
        check_eq("async_field", field, 0);
        check_eq("async_score", score, 0);
        check_eq("async_running", running, 0);
        check_eq("async_mask", bird_col_mask, 0);
        #1 RST = 1'b1;
        tick = 1'b0;

        pulse_start();
        repeat (1200) @(negedge Clock) begin
            tick    = 1'($urandom_range(0, 1));
            collide = ($urandom_range(0, 999) == 0);
        end
        @(negedge Clock) begin tick = 1'b0; collide = 1'b0; end
        @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
